// File: rtl/clk_div_monitor.sv
// ---------------------------------------------------------------------------
// clk_div_monitor
//
// Measures the period and high time (in clk_in cycles) of one divided clock
// sampled on clk_in, then compares them against expected values.
// A measurement starts on a single-cycle start pulse. The first rising edge
// of div_clk starts the counters. The second rising edge stops them and
// produces the result. If either wait lasts too long, the measurement aborts
// with a timeout result.
//
// Optional feature (compile-time macro CLK_MON_SYNC_EN):
//   defined     - div_clk goes through a 2-flop synchronizer before the edge
//                 detect, so asynchronous or external clocks can be monitored.
//                 This adds 2 cycles of start-to-done latency.
//   not defined - div_clk feeds the edge-detect register directly.
//
// Parameters:
//   CNT_W    - width of the counters and of the expected-value inputs
//   TIMEOUT  - maximum clk_in cycles spent in ARM or MEASURE (<= 2^CNT_W-1)
//   DUTY_TOL - allowed |high_time - expected_high|
//
// Ports:
//   clk_in          in   system clock (also clocks the divider stage)
//   rst             in   asynchronous, active-high reset
//   div_clk         in   divided clock under test
//   start           in   single-cycle measurement request (honoured in IDLE)
//   expected_period in   expected period in clk_in cycles
//   expected_high   in   expected high time in clk_in cycles
//   busy            out  high while arming or measuring
//   done            out  one-cycle pulse when a result is valid
//   period          out  measured period (0 on timeout), held until next done
//   high_time       out  measured high time (0 on timeout), held
//   match           out  result passed, held
//   timeout         out  last measurement aborted, held
// ---------------------------------------------------------------------------
module clk_div_monitor #(
   parameter int CNT_W    = 8,
   parameter int TIMEOUT  = 255,
   parameter int DUTY_TOL = 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             div_clk,
   input  logic             start,
   input  logic [CNT_W-1:0] expected_period,
   input  logic [CNT_W-1:0] expected_high,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             match,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   TOL    = (CNT_W+1)'(DUTY_TOL);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high_time;
      logic             match;
      logic             timeout;
   } result_t;

   localparam result_t TIMEOUT_RES = '{period: '0, high_time: '0, match: 1'b0, timeout: 1'b1};

   state_t           state, state_n;
   logic [CNT_W-1:0] wait_cnt, wait_n;
   logic [CNT_W-1:0] period_cnt, pcnt_n;
   logic [CNT_W-1:0] high_cnt, hcnt_n;
   logic             div_s;
   logic             div_q;
   logic             rise;
   logic             load;
   result_t          res, res_n, meas_res;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
`ifdef CLK_MON_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[0], div_clk};
   end

   assign div_s = sync[1];
`else
   assign div_s = div_clk;
`endif

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) div_q <= 1'b0;
      else     div_q <= div_s;
   end

   assign rise = div_s & ~div_q;

   // ------------------------------------------------------------------
   // Result evaluation against the live counter values. This is used on
   // the edge that closes a measurement.
   // ------------------------------------------------------------------
   logic [CNT_W:0] hi_ext, ex_ext, hi_diff;

   always_comb begin
      hi_ext  = {1'b0, high_cnt};
      ex_ext  = {1'b0, expected_high};
      hi_diff = (hi_ext >= ex_ext) ? (hi_ext - ex_ext) : (ex_ext - hi_ext);
      meas_res.period    = period_cnt;
      meas_res.high_time = high_cnt;
      meas_res.match     = (period_cnt == expected_period) && (hi_diff <= TOL);
      meas_res.timeout   = 1'b0;
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Counters increment by at most 1 per cycle. The TIMEOUT compare is made
   // on the incremented value, so a counter stops at TIMEOUT and never wraps.
   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      pcnt_n  = period_cnt;
      hcnt_n  = high_cnt;
      load    = 1'b0;
      res_n   = TIMEOUT_RES;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = ARM;
               wait_n  = '0;
            end
         end
         ARM: begin
            if (rise) begin
               // div_s is already 1 on the rising sample.
               state_n = MEASURE;
               pcnt_n  = CNT_W'(1);
               hcnt_n  = CNT_W'(1);
            end else begin
               wait_n = wait_cnt + 1'b1;
               if (wait_n == TO_VAL) begin
                  state_n = DONE;
                  load    = 1'b1;
               end
            end
         end
         MEASURE: begin
            if (rise) begin
               state_n = DONE;
               load    = 1'b1;
               res_n   = meas_res;
            end else begin
               pcnt_n = period_cnt + 1'b1;
               hcnt_n = high_cnt + CNT_W'(div_s);
               if (pcnt_n == TO_VAL) begin
                  state_n = DONE;
                  load    = 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Counters and held result
   // ------------------------------------------------------------------
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         wait_cnt   <= '0;
         period_cnt <= '0;
         high_cnt   <= '0;
      end else begin
         wait_cnt   <= wait_n;
         period_cnt <= pcnt_n;
         high_cnt   <= hcnt_n;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)       res <= '0;
      else if (load) res <= res_n;
   end

   assign busy      = (state == ARM) || (state == MEASURE);
   assign done      = (state == DONE);
   assign period    = res.period;
   assign high_time = res.high_time;
   assign match     = res.match;
   assign timeout   = res.timeout;

endmodule

// File: tb/tb_clk_div_monitor.sv
// ---------------------------------------------------------------------------
// tb_clk_div_monitor
//
// Randomized bench for clk_div_monitor. div_clk is driven from a
// precomputed waveform table, pat[k], which holds the value present at
// clk_in edge k. The reference model finds rising edges in that table
// (shifted by the synchronizer depth when CLK_MON_SYNC_EN is defined). From
// them it derives the expected done edge, period, high time, match and
// timeout.
// ---------------------------------------------------------------------------
module tb_clk_div_monitor;
   localparam int CNT_W    = 8;
   localparam int TIMEOUT  = 255;
   localparam int DUTY_TOL = 1;
`ifdef CLK_MON_SYNC_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif
   localparam int NPAT = 1 << 17;
   localparam int WIN  = 800;

   logic             clk_in = 1'b0;
   logic             rst    = 1'b0;
   logic             div_clk = 1'b0;
   logic             start  = 1'b0;
   logic [CNT_W-1:0] expected_period = '0;
   logic [CNT_W-1:0] expected_high   = '0;
   logic             busy, done, match, timeout;
   logic [CNT_W-1:0] period, high_time;

   bit pat [NPAT];
   int e = 0;      // index of the next clk_in posedge
   int total = 0;
   int bad = 0;

   clk_div_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .DUTY_TOL(DUTY_TOL)) dut (
      .clk_in(clk_in), .rst(rst), .div_clk(div_clk), .start(start),
      .expected_period(expected_period), .expected_high(expected_high),
      .busy(busy), .done(done), .period(period), .high_time(high_time),
      .match(match), .timeout(timeout)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) begin
      #1;
      e = e + 1;
      div_clk = pat[e % NPAT];
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Value the edge detector sees at edge k
   function automatic bit s_at(input int k);
      if (k - DLY < 0) return 1'b0;
      return pat[(k - DLY) % NPAT];
   endfunction

   function automatic bit rise_at(input int k);
      return s_at(k) && !s_at(k - 1);
   endfunction

   // Rising edges are looked for at most TIMEOUT edges after start. The
   // second rise must follow the first within TIMEOUT-1 edges. Otherwise the
   // run is a timeout.
   task automatic model(input int se, output int dedge, output int r1,
                        output int p, output int h, output bit to);
      int r2;
      r1 = -1; r2 = -1; p = 0; h = 0; to = 1'b1;
      for (int k = se + 1; k <= se + TIMEOUT && r1 < 0; k++)
         if (rise_at(k)) r1 = k;
      if (r1 < 0) begin
         dedge = se + TIMEOUT;
         return;
      end
      for (int k = r1 + 1; k <= r1 + TIMEOUT - 1 && r2 < 0; k++)
         if (rise_at(k)) r2 = k;
      if (r2 < 0) begin
         dedge = r1 + TIMEOUT - 1;
         return;
      end
      dedge = r2;
      p     = r2 - r1;
      for (int k = r1; k < r2; k++) h += int'(s_at(k));
      to = 1'b0;
   endtask

   // mode 0: regular P/H waveform; 1: high time alternates H, H+1 (mixed-edge);
   // 2: constant level H[0]
   task automatic fill(input int mode, input int P, input int H);
      int ph;
      ph = $urandom_range(0, 63);
      for (int i = e + 1; i <= e + WIN; i++) begin
         int n, pos;
         bit v;
         n   = (P > 0) ? (i + ph) / P : 0;
         pos = (P > 0) ? (i + ph) % P : 0;
         case (mode)
            0:       v = (pos < H);
            1:       v = (pos < H + (n % 2));
            default: v = H[0];
         endcase
         pat[i % NPAT] = v;
      end
   endtask

   task automatic measure(input string tag, input int mode, input int P, input int H,
                          input int ep, input int eh, input int settle,
                          input bit repulse, input bit start_at_done, output int lat);
      int se, de, r1, mp, mh, obs;
      bit mto, mm;
      @(posedge clk_in); #2;
      fill(mode, P, H);
      repeat (settle) begin @(posedge clk_in); #2; end
      expected_period = CNT_W'(ep);
      expected_high   = CNT_W'(eh);
      start = 1'b1;
      se = e;
      @(posedge clk_in); #2;
      start = 1'b0;
      model(se, de, r1, mp, mh, mto);
      mm  = !mto && (mp == ep) && ((mh > eh ? mh - eh : eh - mh) <= DUTY_TOL);
      obs = -1;
      lat = -1;
      for (int n = 0; n < WIN && obs < 0; n++) begin
         @(negedge clk_in);
         if (n == 0) chk({tag, " busy"}, busy, 1);
         if (repulse) start = (r1 >= 0 && e - 1 == r1 + 1);
         if (done) obs = e - 1;
      end
      start = 1'b0;
      if (obs < 0) begin
         chk({tag, " done seen"}, 0, 1);
         return;
      end
      lat = obs - se;
      chk({tag, " done edge"}, obs, de);
      chk({tag, " period"},    period, mp);
      chk({tag, " high"},      high_time, mh);
      chk({tag, " match"},     match, mm);
      chk({tag, " timeout"},   timeout, mto);
      if (start_at_done) start = 1'b1;   // lands on the DONE cycle
      @(posedge clk_in); #2;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         chk({tag, " post done"}, done, 0);
         chk({tag, " post busy"}, busy, 0);
      end
   endtask

   initial begin
      int lat, lat2, se, de, r1, mp, mh, nd, P, H, mode, ep, eh;
      bit mto;
      for (int i = 0; i < NPAT; i++) pat[i] = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst period", period, 0);
      chk("rst high", high_time, 0);
      chk("rst match", match, 0);
      chk("rst timeout", timeout, 0);
      repeat (3) @(posedge clk_in);
      #2 rst = 1'b0;

      // Reference cases
      measure("div2", 0, 2, 1, 2, 1, 4, 0, 0, lat);
      measure("div28", 0, 28, 14, 28, 14, 4, 0, 0, lat);
      measure("div28 bad exp", 0, 28, 14, 27, 14, 4, 0, 0, lat);
      for (int i = 0; i < 8; i++)
         measure("div5 mixed", 1, 5, 2, 5, 2, (i == 0) ? 4 : 0, 0, i[0], lat);

      // Stuck inputs: no rise, so ARM aborts TIMEOUT edges after the start
      // edge (the done cycle is TIMEOUT+1 cycles after the start cycle).
      measure("stuck0", 2, 0, 0, 5, 2, 6, 0, 0, lat);
      chk("stuck0 latency", lat, TIMEOUT);
      measure("stuck1", 2, 0, 1, 5, 2, 6, 0, 0, lat);
      chk("stuck1 latency", lat, TIMEOUT);

      // div-by-16: start latency from the first rise. With the synchronizer,
      // the done edge is two edges later relative to the raw waveform.
      measure("div16", 0, 16, 8, 16, 8, 4, 0, 0, lat);
      chk("div16 period", period, 16);
      chk("div16 high", high_time, 8);

      // Longest measurable period, then one past it.
      measure("p254", 0, 254, 100, 254, 100, 4, 0, 0, lat);
      measure("p255", 0, 255, 100, 255, 100, 4, 0, 0, lat);

      // Randomized waveforms and expectations
      for (int i = 0; i < 20; i++) begin
         P    = $urandom_range(2, 60);
         H    = $urandom_range(1, P - 1);
         mode = (H <= P - 2) ? int'($urandom_range(0, 1)) : 0;
         ep   = P + int'($urandom_range(0, 2)) - 1;
         eh   = H + int'($urandom_range(0, 4)) - 2;
         if (eh < 0) eh = 0;
         measure("rand", mode, P, H, ep, eh, $urandom_range(0, 3), 0, $urandom_range(0, 1), lat2);
      end

      // start re-pulsed during MEASURE is ignored: exactly one done
      measure("repulse", 0, 40, 20, 40, 20, 4, 1, 0, lat);
      nd = 0;
      repeat (60) begin
         @(negedge clk_in);
         if (done) nd++;
      end
      chk("repulse extra done", nd, 0);

      // Reset in the middle of MEASURE
      @(posedge clk_in); #2;
      fill(0, 40, 20);
      expected_period = 8'd40;
      expected_high   = 8'd20;
      start = 1'b1;
      se = e;
      @(posedge clk_in); #2;
      start = 1'b0;
      model(se, de, r1, mp, mh, mto);
      for (int n = 0; n < 200 && e - 1 < r1 + 5; n++) @(negedge clk_in);
      chk("mid busy before rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid rst busy", busy, 0);
      chk("mid rst done", done, 0);
      chk("mid rst period", period, 0);
      chk("mid rst high", high_time, 0);
      chk("mid rst match", match, 0);
      chk("mid rst timeout", timeout, 0);
      nd = 0;
      repeat (3) begin
         @(negedge clk_in);
         if (done) nd++;
      end
      @(posedge clk_in); #2;
      rst = 1'b0;
      repeat (50) begin
         @(negedge clk_in);
         if (done || busy) nd++;
      end
      chk("mid rst no done", nd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
